prog_loader: RTL
================

# prog_loader

Boot-time program loader for the 16-bit MCU. It accepts a framed byte stream (from a UART receiver or host bridge), assembles big-endian 16-bit instruction words, and writes them into program memory. It holds the core idle until a frame with a valid checksum completes, then asserts `core_run`. It sits directly upstream of the program memory and the PC/stack block: it fills the memory the PC fetches from, and gates when fetching starts.

## Interface
- `ADDR_W`, 12, program-memory address width (matches the PC width)
- `DATA_W`, 16, instruction width; fixed at 2 bytes
- `MAGIC`, 8'hA5, frame start byte
- `TIMEOUT_CYC`, 1_000_000, maximum number of idle cycles between bytes inside a frame
- `clk` in 1: system clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `rx_valid` in 1: `rx_data` holds a byte
- `rx_data` in 8: incoming byte
- `rx_ready` out 1: loader can accept a byte; a transfer occurs when `rx_valid && rx_ready`
- `load_req` in 1: single-cycle request to abort or restart loading
- `pm_we` out 1: program-memory write strobe, one cycle wide
- `pm_addr` out ADDR_W: write address
- `pm_wdata` out DATA_W: write data
- `core_run` out 1: core released; the core is held in reset while this is low
- `err` out 1: loader halted on an error
- `err_code` out 2: 00 none, 01 checksum, 10 length, 11 timeout

## Operation
- Frame format: `MAGIC`, CNT_H, CNT_L, then CNT words each sent as HI byte then LO byte, then CHK.
- CHK is the XOR of every byte after `MAGIC` and before CHK.
- FSM states: IDLE, CNT_H, CNT_L, DATA_H, DATA_L, CHK, RUN, ERR.
- IDLE: bytes other than `MAGIC` are accepted and discarded. `MAGIC` moves to CNT_H and clears the XOR accumulator and the word address.
- CNT_L accepted:
  - count > 2^ADDR_W → ERR, code 10.
  - count = 0 → CHK.
  - otherwise → DATA_H.
- DATA_H latches the HI byte.
- DATA_L accepted:
  - Schedules a write of {HI, LO} to the current address, then increments the address.
  - When the address reaches count → CHK; otherwise → DATA_H.
- CHK accepted:
  - Byte equals the accumulator → RUN.
  - Otherwise → ERR, code 01.
- Any byte that is accepted before CHK is XORed into the accumulator, including count bytes.
- RUN: `core_run`=1, `rx_ready`=0. Only `load_req` leaves RUN (→ IDLE).
- ERR: `err`=1, `rx_ready`=0, `core_run`=0. `err_code` is held until `load_req` (→ IDLE, `err_code` cleared).
- `load_req` in any state → IDLE next cycle, with `core_run` and `err` cleared. `load_req` has priority over a byte transfer in the same cycle; that byte is dropped.
- Timeout counter:
  - Runs only in CNT_H through CHK.
  - Clears on every accepted byte.
  - Reaching `TIMEOUT_CYC` → ERR, code 11.
- `rx_ready` is 1 in IDLE through CHK and 0 in RUN and ERR.
- Program memory is never cleared by the loader. A partial load leaves the words already written.

## Timing
- Reset values: `rx_ready`=1, `pm_we`=0, `pm_addr`=0, `pm_wdata`=0, `core_run`=0, `err`=0, `err_code`=00; state IDLE.
- `rst` mid-frame returns to these values on the next edge. No write is issued after reset.
- `pm_we`, `pm_addr` and `pm_wdata` are registered:
  - `pm_we` is high for exactly one cycle, in the cycle after the DATA_L handshake.
  - Address and data are valid in that same cycle.
- A write strobe already registered in the cycle `load_req` is taken still completes.
- `core_run` rises 1 cycle after a matching CHK handshake.
- `err` rises 1 cycle after the failing handshake, or after the timeout cycle.
- Throughput: one byte per cycle; back-to-back `rx_valid` needs no stall.
- Address wrap is impossible: count is limited to 2^ADDR_W, so the last address is 2^ADDR_W−1.

## Structure
- Shared package `mcu_pkg` holds: the loader state enum, the `err_code` constants, and the `MAGIC` default.
- One sub-module, `loader_timeout`: a counter with clear and enable inputs and a `expired` output, parameterised by `TIMEOUT_CYC` with width $clog2(TIMEOUT_CYC+1).
- The FSM, accumulator, HI-byte latch and address counter stay in `prog_loader`.

## Test plan
- Frame A5 00 02 12 34 AB CD with CHK = 00^02^12^34^AB^CD = 0x42 → `pm_we` pulses: addr 0 data 0x1234, addr 1 data 0xABCD; `core_run`=1 one cycle after CHK.
- Same frame with CHK = 0x43 → both words written; `err`=1, `err_code`=01, `core_run` stays 0.
- Leading bytes 00 FF, then A5 00 00 00 → noise discarded; no `pm_we`; `core_run`=1.
- A5 10 01 (count 4097) → ERR, code 10, no writes. Then `load_req` → IDLE, `err`=0.
- A5 00 01 12, then `rx_valid` low for `TIMEOUT_CYC` cycles → ERR, code 11. Assert `rst` mid-frame in a second run → all outputs at reset values next cycle.
- In RUN, pulse `load_req` with `rx_valid` high → `core_run`=0 next cycle; that byte is not consumed as `MAGIC`.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared MCU definitions used by the boot-time program loader.
// Covers the loader state encoding, error codes and the frame start byte.
package mcu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_H,
    S_CNT_L,
    S_DATA_H,
    S_DATA_L,
    S_CHK,
    S_RUN,
    S_ERR
  } loader_state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CHK  = 2'b01;
  localparam logic [1:0] ERR_LEN  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

endpackage

// File: rtl/loader_timeout.sv
// Counts idle cycles while enabled and flags the cycle in which the limit is reached.
// Any clear, or dropping the enable, restarts the count from zero.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fires during the TIMEOUT_CYC-th consecutive idle cycle.
  assign expired = en && !clr && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (!expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses framed bytes into big-endian words, writes program memory,
// and releases the core only after a frame with a matching XOR checksum.
module prog_loader
  import mcu_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter int          DATA_W      = 16,
  parameter logic [7:0]  MAGIC       = MAGIC_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [DATA_W-1:0] pm_wdata,
  output logic              core_run,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [31:0] MAX_CNT = 32'd1 << ADDR_W;

  loader_state_e     state_q, state_d;
  logic [7:0]        acc_q, acc_d;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              pm_we_q, pm_we_d;
  logic [ADDR_W-1:0] pm_addr_q, pm_addr_d;
  logic [DATA_W-1:0] pm_wdata_q, pm_wdata_d;

  logic              xfer;
  logic              tmo_en;
  logic              expired;
  logic [ADDR_W:0]   addr_next;
  logic [31:0]       cnt_word;

  assign rx_ready  = (state_q != S_RUN) && (state_q != S_ERR);
  assign xfer      = rx_valid && rx_ready;
  assign tmo_en    = (state_q != S_IDLE) && rx_ready;
  // One extra bit so that a full 2^ADDR_W-word frame still compares against its count.
  assign addr_next = {1'b0, addr_q} + (ADDR_W + 1)'(1);
  assign cnt_word  = 32'({cnt_q[15:8], rx_data});

  loader_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (xfer),
    .en     (tmo_en),
    .expired(expired)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    err_code_d = err_code_q;
    pm_we_d    = 1'b0;
    pm_addr_d  = pm_addr_q;
    pm_wdata_d = pm_wdata_q;

    if (load_req) begin
      state_d    = S_IDLE;
      err_code_d = ERR_NONE;
    end else if (expired) begin
      state_d    = S_ERR;
      err_code_d = ERR_TMO;
    end else if (xfer) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == MAGIC) begin
            state_d = S_CNT_H;
            acc_d   = 8'h00;
            addr_d  = '0;
          end
        end
        S_CNT_H: begin
          cnt_d[15:8] = rx_data;
          acc_d       = acc_q ^ rx_data;
          state_d     = S_CNT_L;
        end
        S_CNT_L: begin
          cnt_d[7:0] = rx_data;
          acc_d      = acc_q ^ rx_data;
          if (cnt_word > MAX_CNT) begin
            state_d    = S_ERR;
            err_code_d = ERR_LEN;
          end else if (cnt_word == 32'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA_H;
          end
        end
        S_DATA_H: begin
          hi_d    = rx_data;
          acc_d   = acc_q ^ rx_data;
          state_d = S_DATA_L;
        end
        S_DATA_L: begin
          acc_d      = acc_q ^ rx_data;
          pm_we_d    = 1'b1;
          pm_addr_d  = addr_q;
          pm_wdata_d = DATA_W'({hi_q, rx_data});
          addr_d     = addr_next[ADDR_W-1:0];
          state_d    = (32'(addr_next) == 32'(cnt_q)) ? S_CHK : S_DATA_H;
        end
        S_CHK: begin
          if (rx_data == acc_q) begin
            state_d = S_RUN;
          end else begin
            state_d    = S_ERR;
            err_code_d = ERR_CHK;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= 8'h00;
      hi_q       <= 8'h00;
      cnt_q      <= 16'h0000;
      addr_q     <= '0;
      err_code_q <= ERR_NONE;
      pm_we_q    <= 1'b0;
      pm_addr_q  <= '0;
      pm_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      err_code_q <= err_code_d;
      pm_we_q    <= pm_we_d;
      pm_addr_q  <= pm_addr_d;
      pm_wdata_q <= pm_wdata_d;
    end
  end

  assign pm_we    = pm_we_q;
  assign pm_addr  = pm_addr_q;
  assign pm_wdata = pm_wdata_q;
  assign core_run = (state_q == S_RUN);
  assign err      = (state_q == S_ERR);
  assign err_code = err_code_q;

endmodule
